// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DROP
    } ifu_state_t;

    localparam logic [31:0] RV_NOP           = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_timeout_cnt.sv
// rtl/ifu_timeout_cnt.sv - saturating response-wait counter; expire pulses on the LIMIT-th enabled cycle
module ifu_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] MAX  = W'(LIMIT);
    localparam logic [W-1:0] LAST = (LIMIT < 1) ? '0 : W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

    // A limit of zero disables the timeout entirely.
    assign expire = (LIMIT != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit between core PC and instruction memory
// Optional IFU_PERF_CNT_EN adds fetch/stall performance counters.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_i,
    input  logic        pc_valid,
    input  logic        flush,
    output logic [31:0] inst_o,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        inst_err,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    ifu_state_t  state_q, state_d;
    logic [31:0] inst_d, addr_d;
    logic        ivalid_d, ierr_d, reqv_d;
    logic        drop_pend_q, drop_pend_d;
    logic        accept_pc;
    logic        expire;

    ifu_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != ST_WAIT),
        .enable (state_q == ST_WAIT),
        .expire (expire)
    );

    always_comb begin
        state_d     = state_q;
        inst_d      = inst_o;
        ierr_d      = inst_err;
        ivalid_d    = inst_valid;
        reqv_d      = imem_req_valid;
        addr_d      = imem_addr;
        drop_pend_d = drop_pend_q;
        accept_pc   = 1'b0;

        case (state_q)
            ST_IDLE: accept_pc = pc_valid;
            ST_REQ: begin
                // A flushed request still completes its handshake before being dropped.
                if (flush) drop_pend_d = 1'b1;
                if (imem_req_ready) begin
                    reqv_d      = 1'b0;
                    drop_pend_d = 1'b0;
                    state_d     = (flush || drop_pend_q) ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = imem_rsp_valid ? ST_IDLE : ST_DROP;
                end else if (imem_rsp_valid) begin
                    inst_d   = imem_rsp_data;
                    ierr_d   = imem_rsp_err;
                    ivalid_d = 1'b1;
                    state_d  = ST_HOLD;
                end else if (expire) begin
                    inst_d   = RV_NOP;
                    ierr_d   = 1'b1;
                    ivalid_d = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (flush || inst_ready) begin
                    ivalid_d  = 1'b0;
                    state_d   = ST_IDLE;
                    accept_pc = pc_valid;
                end
            end
            ST_DROP: if (imem_rsp_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Misaligned PCs never reach memory; they complete immediately as an error.
        if (accept_pc) begin
            addr_d = {pc_i[31:2], 2'b00};
            if (pc_i[1:0] != 2'b00) begin
                inst_d   = RV_NOP;
                ierr_d   = 1'b1;
                ivalid_d = 1'b1;
                state_d  = ST_HOLD;
            end else begin
                reqv_d  = 1'b1;
                state_d = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            inst_o         <= RV_NOP;
            inst_err       <= 1'b0;
            inst_valid     <= 1'b0;
            imem_req_valid <= 1'b0;
            imem_addr      <= RESET_PC;
            drop_pend_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            inst_o         <= inst_d;
            inst_err       <= ierr_d;
            inst_valid     <= ivalid_d;
            imem_req_valid <= reqv_d;
            imem_addr      <= addr_d;
            drop_pend_q    <= drop_pend_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (inst_valid && inst_ready) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (state_q inside {ST_REQ, ST_WAIT, ST_DROP}) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
